// File: rtl/votrax_pkg.sv
// Shared definitions for the speech-chip sequencer: phone duration table,
// pause code and the sequencer state encoding.
package votrax_pkg;

    localparam logic [5:0] PHONE_PAUSE = 6'h3F;

    typedef enum logic [1:0] {IDLE, ARM, PLAY} state_t;

    // Duration of each phone in frame units; a zero entry still plays one frame.
    localparam logic [5:0] DUR_TABLE [64] = '{
        6'd0,  6'd5,  6'd9,  6'd12, 6'd7,  6'd14, 6'd8,  6'd6,
        6'd11, 6'd4,  6'd10, 6'd13, 6'd6,  6'd9,  6'd15, 6'd7,
        6'd8,  6'd12, 6'd5,  6'd10, 6'd16, 6'd6,  6'd11, 6'd9,
        6'd7,  6'd13, 6'd4,  6'd8,  6'd12, 6'd18, 6'd6,  6'd10,
        6'd9,  6'd5,  6'd14, 6'd7,  6'd11, 6'd8,  6'd13, 6'd6,
        6'd10, 6'd12, 6'd4,  6'd15, 6'd9,  6'd7,  6'd11, 6'd5,
        6'd8,  6'd14, 6'd6,  6'd10, 6'd12, 6'd3,  6'd9,  6'd16,
        6'd7,  6'd11, 6'd5,  6'd13, 6'd8,  6'd10, 6'd6,  6'd12
    };

    function automatic logic [5:0] phone_dur(input logic [5:0] code);
        logic [5:0] d;
        d = DUR_TABLE[code];
        return (d == 6'd0) ? 6'd1 : d;
    endfunction

endpackage

// File: rtl/votrax_ce_gen.sv
// Fractional clock-enable generator: ce rate = clk * CE_NUM / CE_DEN,
// one clk cycle wide, free-running out of reset.
module votrax_ce_gen #(
    parameter int CE_NUM = 3,
    parameter int CE_DEN = 200
) (
    input  logic clk,
    input  logic reset,
    output logic ce
);

    localparam int ACC_W = $clog2(CE_DEN + CE_NUM);
    localparam logic [ACC_W-1:0] NUM_W = ACC_W'(CE_NUM);
    localparam logic [ACC_W-1:0] DEN_W = ACC_W'(CE_DEN);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

    // acc never exceeds CE_DEN-1, so acc + CE_NUM always fits in ACC_W bits.
    assign acc_next = acc + NUM_W;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (acc_next >= DEN_W) begin
            acc <= acc_next - DEN_W;
            ce  <= 1'b1;
        end else begin
            acc <= acc_next;
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/votrax_phone_sequencer.sv
// Speech-chip sequencer: latches CPU phone writes, strobes the speech core
// and times each phone to drive the AR ready line.
//
// state | meaning
// IDLE  | no phone playing, ar = 1
// ARM   | phone latched, stb held until the next ce
// PLAY  | counting frames of the current phone, ar = 0
module votrax_phone_sequencer
    import votrax_pkg::*;
#(
    parameter int CE_NUM      = 3,
    parameter int CE_DEN      = 200,
    parameter int FRAME_TICKS = 3600,
    parameter int INVERT_IN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] wr_data,
    output logic       ce,
    output logic [5:0] phone,
    output logic [1:0] infl,
    output logic       stb,
    output logic       ar,
    output logic       busy
);

    localparam int FRAME_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FRAME_TICKS - 1);

    state_t state, state_next;
    logic [5:0] phone_next;
    logic [1:0] infl_next;
    logic stb_next, ar_next;
    logic [FRAME_W-1:0] frame_cnt, frame_next;
    logic [5:0] dur_cnt, dur_next;
    logic [5:0] in_phone;
    logic [1:0] in_infl;

    votrax_ce_gen #(
        .CE_NUM(CE_NUM),
        .CE_DEN(CE_DEN)
    ) u_ce_gen (
        .clk   (clk),
        .reset (reset),
        .ce    (ce)
    );

    assign in_phone = (INVERT_IN != 0) ? ~wr_data[5:0] : wr_data[5:0];
    assign in_infl  = (INVERT_IN != 0) ? ~wr_data[7:6] : wr_data[7:6];
    assign busy     = ~ar;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            phone     <= PHONE_PAUSE;
            infl      <= 2'd0;
            stb       <= 1'b0;
            ar        <= 1'b1;
            frame_cnt <= '0;
            dur_cnt   <= 6'd0;
        end else begin
            state     <= state_next;
            phone     <= phone_next;
            infl      <= infl_next;
            stb       <= stb_next;
            ar        <= ar_next;
            frame_cnt <= frame_next;
            dur_cnt   <= dur_next;
        end
    end

    always_comb begin
        state_next = state;
        phone_next = phone;
        infl_next  = infl;
        stb_next   = stb;
        ar_next    = ar;
        frame_next = frame_cnt;
        dur_next   = dur_cnt;
        // A write restarts the phone from any state, even when it meets a ce.
        if (wr) begin
            phone_next = in_phone;
            infl_next  = in_infl;
            stb_next   = 1'b1;
            ar_next    = 1'b0;
            state_next = ARM;
        end else begin
            case (state)
                IDLE: ;
                ARM: begin
                    if (ce) begin
                        dur_next   = phone_dur(phone);
                        frame_next = '0;
                        stb_next   = 1'b0;
                        state_next = PLAY;
                    end
                end
                PLAY: begin
                    if (ce) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_next = '0;
                            dur_next   = dur_cnt - 6'd1;
                            if (dur_cnt == 6'd1) begin
                                ar_next    = 1'b1;
                                state_next = IDLE;
                            end
                        end else begin
                            frame_next = frame_cnt + 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_votrax_phone_sequencer.sv
// Bench for the speech-chip sequencer: cycle-by-cycle comparison against a
// tick-countdown reference model, plus directed timing scenarios.
module tb_votrax_phone_sequencer;
    import votrax_pkg::*;

    localparam int NUM = 3;
    localparam int DEN = 20;
    localparam int FT  = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic ce, stb, ar, busy;
    logic [5:0] phone;
    logic [1:0] infl;

    logic def_wr = 1'b0;
    logic [7:0] def_data = 8'h00;
    logic d_ce, d_stb, d_ar, d_busy;
    logic [5:0] d_phone;
    logic [1:0] d_infl;

    always #5 clk = ~clk;

    votrax_phone_sequencer #(
        .CE_NUM(NUM), .CE_DEN(DEN), .FRAME_TICKS(FT), .INVERT_IN(1)
    ) dut (
        .clk(clk), .reset(reset), .wr(wr), .wr_data(wr_data),
        .ce(ce), .phone(phone), .infl(infl), .stb(stb), .ar(ar), .busy(busy)
    );

    votrax_phone_sequencer dut_def (
        .clk(clk), .reset(reset), .wr(def_wr), .wr_data(def_data),
        .ce(d_ce), .phone(d_phone), .infl(d_infl), .stb(d_stb), .ar(d_ar), .busy(d_busy)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int n;
    bit m_ce;
    logic [5:0] m_phone;
    logic [1:0] m_infl;
    bit m_armed, m_busy;
    int m_left;
    int play_ce;
    int def_n, def_last, def_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ce_at(input int k);
        return ((k * NUM) / DEN) != (((k - 1) * NUM) / DEN);
    endfunction

    task automatic model_reset();
        n = 0; m_ce = 0; m_phone = PHONE_PAUSE; m_infl = 2'd0;
        m_armed = 0; m_busy = 0; m_left = 0; play_ce = 0;
        def_n = 0; def_last = 0; def_cnt = 0;
    endtask

    task automatic model_edge(input logic w, input logic [7:0] d);
        int dur;
        if (w) begin
            m_phone = ~d[5:0];
            m_infl  = ~d[7:6];
            m_armed = 1; m_busy = 1;
        end else if (m_armed && m_ce) begin
            dur = int'(DUR_TABLE[m_phone]);
            if (dur == 0) dur = 1;
            m_armed = 0;
            m_left  = dur * FT;
        end else if (m_busy && m_ce) begin
            m_left--;
            if (m_left == 0) m_busy = 0;
        end
        n++;
        m_ce = ce_at(n);
    endtask

    task automatic cyc(input logic w, input logic [7:0] d);
        wr = w; wr_data = d;
        @(posedge clk);
        model_edge(w, d);
        @(negedge clk);
        check("ce", ce, m_ce);
        check("ar", ar, !m_busy);
        check("busy", busy, m_busy);
        check("stb", stb, m_armed);
        check("phone", phone, m_phone);
        check("infl", infl, m_infl);
        if (stb) play_ce = 0;
        else if (!ar && ce) play_ce++;
        def_n++;
        if (d_ce) begin
            if (def_last > 0) check("def_gap", ((def_n - def_last) == 66) || ((def_n - def_last) == 67), 1);
            def_last = def_n;
            def_cnt++;
        end
    endtask

    task automatic run_idle(input int max);
        int i = 0;
        while (m_busy && i < max) begin
            cyc(1'b0, 8'h00);
            i++;
        end
        check("idle_timeout", m_busy, 0);
    endtask

    task automatic wait_arm_ce(input int max);
        int i = 0;
        while (!(m_armed && m_ce) && i < max) begin
            cyc(1'b0, 8'h00);
            i++;
        end
        check("arm_ce_timeout", m_armed && m_ce, 1);
    endtask

    initial begin
        int half, i;
        logic [7:0] rd;
        model_reset();

        // reset state, with a write attempted during reset
        wr = 1'b1; wr_data = 8'h12;
        repeat (2) @(negedge clk);
        check("rst_ar", ar, 1);
        check("rst_stb", stb, 0);
        check("rst_phone", phone, 6'h3F);
        check("rst_infl", infl, 0);
        check("rst_ce", ce, 0);
        check("rst_busy", busy, 0);
        wr = 1'b0;
        reset = 1'b0;
        model_reset();

        // default-rate ce: 3 pulses per 200 clk
        repeat (400) cyc(1'b0, 8'h00);
        check("def_ce_count", def_cnt, 6);
        check("def_ar", d_ar, 1);

        // pause phone
        cyc(1'b1, 8'hC0);
        check("c0_phone", phone, 6'h3F);
        check("c0_ar", ar, 0);
        run_idle(3000);
        check("dur_3f", play_ce, int'(DUR_TABLE[6'h3F]) * FT);

        // phone 05 interrupted halfway by phone 0A
        cyc(1'b1, 8'hFA);
        check("fa_phone", phone, 6'h05);
        wait_arm_ce(100);
        half = (int'(DUR_TABLE[6'h05]) * FT) / 2;
        i = 0;
        cyc(1'b0, 8'h00);
        while (m_left > half && i < 3000) begin
            cyc(1'b0, 8'h00);
            i++;
        end
        cyc(1'b1, 8'hF5);
        check("f5_phone", phone, 6'h0A);
        check("f5_stb", stb, 1);
        check("f5_ar", ar, 0);
        run_idle(3000);
        check("dur_0a", play_ce, int'(DUR_TABLE[6'h0A]) * FT);

        // write coinciding with ce while armed
        cyc(1'b1, 8'hE3);
        wait_arm_ce(100);
        cyc(1'b1, 8'hD9);
        check("coinc_stb", stb, 1);
        check("coinc_phone", phone, 6'h26);
        run_idle(3000);
        check("dur_26", play_ce, int'(DUR_TABLE[6'h26]) * FT);

        // zero table entry plays one frame
        cyc(1'b1, 8'hFF);
        run_idle(3000);
        check("dur_zero", play_ce, FT);

        // reset in the middle of a phone
        cyc(1'b1, 8'h3B);
        check("3b_infl", infl, 2'd3);
        wait_arm_ce(100);
        repeat (5) cyc(1'b0, 8'h00);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_ar", ar, 1);
        check("mid_rst_stb", stb, 0);
        check("mid_rst_phone", phone, 6'h3F);
        check("mid_rst_infl", infl, 0);
        wr = 1'b1; wr_data = 8'h00;
        repeat (2) @(negedge clk);
        check("mid_rst_hold_ar", ar, 1);
        wr = 1'b0;
        reset = 1'b0;
        model_reset();
        cyc(1'b0, 8'h00);
        cyc(1'b1, 8'hC5);
        run_idle(3000);
        check("dur_3a", play_ce, int'(DUR_TABLE[6'h3A]) * FT);

        // random writes, including restarts during ARM and PLAY
        for (int k = 0; k < 6000; k++) begin
            rd = 8'($urandom);
            cyc(($urandom_range(0, 119) == 0), rd);
        end
        run_idle(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/votrax_phone_sequencer.md
Name: votrax_phone_sequencer

Overview:
- Controls the speech chip on the sound board: converts sound-CPU writes into phone/inflection latches and a strobe that meets the speech core's clock-enable timing.
- Times each phone from a per-phone duration table and drives the AR (ready) line that the sound CPU samples as NMI and on the RIOT port B.
- Generates the 720 kHz clock enable for the speech core in the clk domain, so no derived clock and no CDC are needed.

Parameters:
- CE_NUM, 3, clock-enable accumulator increment (ce rate = clk × CE_NUM / CE_DEN).
- CE_DEN, 200, accumulator modulus; the defaults give 720 kHz from a 48 MHz clk.
- FRAME_TICKS, 3600, ce ticks per duration unit (5 ms at 720 kHz).
- INVERT_IN, 1, when 1: phone = ~wr_data[5:0] and infl = ~wr_data[7:6].

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous, active-high.
- wr, in, 1, one-cycle CPU write strobe to the speech address.
- wr_data, in, 8, CPU data bus.
- ce, out, 1, speech-core clock enable, one clk cycle wide.
- phone, out, 6, latched phone code to the speech core.
- infl, out, 2, latched inflection.
- stb, out, 1, phone strobe to the speech core.
- ar, out, 1, ready: 1 = idle, 0 = phone playing.
- busy, out, 1, equals ~ar; provided for debug.

Behaviour:
- Reset values:
  - ce = 0, phone = 6'h3F (pause), infl = 0, stb = 0, ar = 1.
  - Accumulator, frame counter and duration counter = 0.
  - State = IDLE.
- Clock enable:
  - Each clk: acc_next = acc + CE_NUM.
  - If acc_next ≥ CE_DEN: acc ← acc_next − CE_DEN and ce = 1 in that cycle; otherwise acc ← acc_next.
  - Accumulator width is clog2(CE_DEN + CE_NUM).
  - ce runs continuously out of reset, independent of state.
- State machine with states IDLE, ARM and PLAY.
  - IDLE: on wr, latch phone/infl (INVERT_IN applied) in that cycle, set stb = 1, ar = 0, go to ARM.
  - ARM: stb stays 1 until a cycle with ce = 1, inclusive. In that cycle:
    - load dur_cnt = DUR_TABLE[phone], forced to 1 if the table entry is 0;
    - clear frame_cnt;
    - go to PLAY, with stb = 0 from the next cycle.
    - If wr and ce coincide in ARM, the write wins: relatch, stay in ARM, stb stays 1, no load.
  - PLAY: on each ce, frame_cnt increments.
    - At frame_cnt = FRAME_TICKS−1 with ce: frame_cnt ← 0 and dur_cnt ← dur_cnt − 1.
    - When dur_cnt reaches 0: ar ← 1, go to IDLE. ar rises the clk cycle after the final ce.
- Writes during PLAY match the real chip and restart the phone:
  - relatch phone/infl, stb ← 1, go to ARM, ar stays 0.
  - No queueing; the previous phone is abandoned.
- Phone duration:
  - Exactly DUR_TABLE[phone] × FRAME_TICKS ce ticks, counted from the first ce after the write.
  - Total latency from wr to ar rising = (ce ticks up to the first ce) + that count, ± 0 cycles.
- Inflection does not affect duration.
- wr during reset is ignored.
- Reset asserted mid-phone returns all outputs to reset values immediately (asynchronous).

Decomposition:
- Package votrax_pkg:
  - DUR_TABLE: 64 × 6-bit durations, in FRAME_TICKS units.
  - PHONE_PAUSE = 6'h3F.
  - State enum {IDLE, ARM, PLAY}.
- Sub-module votrax_ce_gen (fractional ce accumulator), reused by any other fixed-rate peripheral on the board.

Test Plan:
- Reset release: ar = 1, phone = 3F, stb = 0. With defaults, ce pulses exactly 3 times per 200 clk, with 66 or 67 cycles between pulses.
- wr_data = 8'hC0 with INVERT_IN = 1:
  - next cycle phone = 3F, infl = 0, ar = 0;
  - stb high through the next ce;
  - ar returns to 1 exactly DUR_TABLE[3F] × 3600 ce ticks later.
- Write phone 05 (wr_data = 8'hFA), then write wr_data = 8'hF5 halfway through the phone:
  - phone = 0A, stb reasserts, ar stays 0;
  - total ar-low time = half of phone 05 + the full duration of phone 0A.
- wr asserted in the same cycle as ce while in ARM: latch updates, stb held, the duration load occurs on the following ce.
- Table entry 0 (patch test table): ar-low lasts exactly 1 × FRAME_TICKS ce ticks.
- Assert reset during PLAY: ar = 1, stb = 0, phone = 3F in the same cycle. A write after release behaves like a fresh IDLE write.
